enoc_net_adapter: RTL

// Buffered, parametrised interface between NetEmulation ports (packet_t carrying .valid) and an ENoC mesh
// (separate data/valid/enable per node). Per-port ingress FIFOs hold each packet until the mesh enables it.

---
 rtl/enoc_pkg.sv | 19 +
 rtl/enoc_ingress_fifo.sv | 66 ++++++
 rtl/enoc_net_adapter.sv | 76 +++++++
 3 files changed

// File: rtl/enoc_pkg.sv
// Shared types and defaults for the NetEmulation <-> ENoC adapter.
package enoc_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned DEST_W         = 6;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_NF_THRESH  = 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              valid;
  } packet_t;

  function automatic int unsigned enoc_nodes(input int unsigned x_nodes, input int unsigned y_nodes);
    return x_nodes * y_nodes;
  endfunction

endpackage

// File: rtl/enoc_ingress_fifo.sv
// One port's ingress FIFO: holds packets until the mesh node enables them.
module enoc_ingress_fifo
  import enoc_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned NF_THRESH = DEF_NF_THRESH
) (
  input  logic    clk,
  input  logic    rst,
  input  packet_t pkt_i,
  input  logic    pop_en_i,
  output packet_t head_c,
  output logic    val_o,
  output logic    full_o,
  output logic    nearly_full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  packet_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            push_c;
  logic            pop_c;

  // A full FIFO refuses pushes even when a pop frees a slot the same cycle.
  assign push_c = pkt_i.valid && !full_o;
  assign pop_c  = val_o && pop_en_i;
  assign head_c = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from next count so they move only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      val_o         <= 1'b0;
      full_o        <= 1'b0;
      nearly_full_o <= 1'b0;
    end else begin
      count_q       <= count_d;
      val_o         <= (count_d != '0);
      full_o        <= (count_d == CW'(DEPTH));
      nearly_full_o <= ((CW'(DEPTH) - count_d) <= CW'(NF_THRESH));
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= pkt_i;
  end

endmodule

// File: rtl/enoc_net_adapter.sv
// Buffered adapter between NetEmulation packet ports and the ENoC mesh node interface.
module enoc_net_adapter
  import enoc_pkg::*;
#(
  parameter int unsigned PORTS      = 16,
  parameter int unsigned X_NODES    = 4,
  parameter int unsigned Y_NODES    = 4,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned NF_THRESH  = DEF_NF_THRESH,
  localparam int unsigned NODES     = enoc_nodes(X_NODES, Y_NODES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  packet_t [PORTS-1:0]  pkt_in,
  output packet_t [PORTS-1:0]  pkt_out,
  output logic    [PORTS-1:0]  net_full,
  output logic    [PORTS-1:0]  nearly_full,
  output packet_t [NODES-1:0]  enoc_i_data,
  output logic    [NODES-1:0]  enoc_i_val,
  input  logic    [NODES-1:0]  enoc_o_en,
  input  packet_t [NODES-1:0]  enoc_o_data,
  input  logic    [NODES-1:0]  enoc_o_val,
  output logic    [NODES-1:0]  enoc_i_en
);

  if (PORTS > NODES) begin : g_err_ports
    $error("enoc_net_adapter: PORTS exceeds mesh node count");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
    $error("enoc_net_adapter: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (NF_THRESH >= FIFO_DEPTH) begin : g_err_thresh
    $error("enoc_net_adapter: NF_THRESH must be below FIFO_DEPTH");
  end

  assign enoc_i_en = '1;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic unused_vbit;

    enoc_ingress_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .NF_THRESH (NF_THRESH)
    ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .pkt_i         (pkt_in[p]),
      .pop_en_i      (enoc_o_en[p]),
      .head_c        (enoc_i_data[p]),
      .val_o         (enoc_i_val[p]),
      .full_o        (net_full[p]),
      .nearly_full_o (nearly_full[p])
    );

    // Egress valid comes from o_val, so the payload's own valid bit is ignored.
    assign unused_vbit = enoc_o_data[p].valid;

    always_ff @(posedge clk) begin
      if (rst || !enoc_o_val[p]) begin
        pkt_out[p] <= '0;
      end else begin
        pkt_out[p]       <= enoc_o_data[p];
        pkt_out[p].valid <= 1'b1;
      end
    end
  end

  if (PORTS < NODES) begin : g_pad
    logic unused_pad;
    assign enoc_i_data[NODES-1:PORTS] = '0;
    assign enoc_i_val[NODES-1:PORTS]  = '0;
    assign unused_pad = ^{enoc_o_data[NODES-1:PORTS], enoc_o_val[NODES-1:PORTS],
                          enoc_o_en[NODES-1:PORTS]};
  end

endmodule
